// File: rtl/sr_latch_ctrl_pkg.sv
// Shared encodings and elaboration helpers for the SR latch controller.
package sr_latch_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_RECOV = 2'd2
   } state_e;

   localparam logic OP_SET   = 1'b1;
   localparam logic OP_RESET = 1'b0;

   function automatic int clog2(input int v);
      int res;
      res = 0;
      for (int i = 0; i < 32; i++) begin
         if ((32'd1 << res) < v) begin
            res = res + 1;
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   // Width helper that never returns zero, so 1-deep counters still get a bit.
   function automatic int width_of(input int v);
      return (clog2(v) < 1) ? 1 : clog2(v);
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sr_latch_ctrl_if.sv
// Requester-side bundle: requests in, grant/status out.
interface sr_latch_ctrl_if #(parameter int NREQ = 4);
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] op;
   logic [NREQ-1:0] gnt;
   logic            done;
   logic            busy;
   logic            q_exp;
   logic            err;

   modport master (output req, output op,
                   input gnt, input done, input busy, input q_exp, input err);
   modport slave  (input req, input op,
                   output gnt, output done, output busy, output q_exp, output err);
endinterface

// File: rtl/sr_latch_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [PW-1:0]   win,
   output logic            any
);

   // Scan from the pointer; the first hit wins and blocks later ones.
   always_comb begin
      int idx;
      grant = '0;
      win   = '0;
      any   = 1'b0;
      idx   = 0;
      for (int i = 0; i < NREQ; i++) begin
         idx = (int'(ptr) + i) % NREQ;
         if (!any && req[idx]) begin
            any        = 1'b1;
            grant[idx] = 1'b1;
            win        = PW'(idx);
         end else begin
            any = any;
         end
      end
   end

endmodule

// File: rtl/sr_latch_ctrl.sv
// Shares one NOR SR latch between NREQ requesters: arbitrates, drives
// exclusive width-controlled s/r pulses and checks q feedback after each op.
module sr_latch_ctrl
   import sr_latch_ctrl_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int PULSE_CYC = 2,
   parameter int RECOV_CYC = 1
) (
   input  logic             clk,
   input  logic             rst,
   sr_latch_ctrl_if.slave   bus,
   output logic             s,
   output logic             r,
   input  logic             q_fb
);

   localparam int CW = width_of(max2(PULSE_CYC, RECOV_CYC));
   localparam int PW = width_of(NREQ);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   win_q, win_d;
   logic            op_q, op_d;
   logic            s_q, s_d;
   logic            r_q, r_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            done_q, done_d;
   logic            busy_q, busy_d;
   logic            q_exp_q, q_exp_d;
   logic            err_q, err_d;

   logic [NREQ-1:0] arb_grant;
   logic [PW-1:0]   arb_win;
   logic            arb_any;

   rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
      .req   (bus.req),
      .ptr   (ptr_q),
      .grant (arb_grant),
      .win   (arb_win),
      .any   (arb_any)
   );

   // Next-state and output decode; s/r come straight from the PULSE state so
   // they are registered one cycle behind the grant and can never overlap.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      op_d    = op_q;
      q_exp_d = q_exp_q;
      err_d   = err_q;
      gnt_d   = '0;
      done_d  = 1'b0;
      s_d     = 1'b0;
      r_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               state_d = ST_PULSE;
               gnt_d   = arb_grant;
               win_d   = arb_win;
               op_d    = bus.op[arb_win];
               cnt_d   = CW'(PULSE_CYC - 1);
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PULSE: begin
            s_d = (op_q == OP_SET);
            r_d = (op_q == OP_RESET);
            if (cnt_q == '0) begin
               state_d = ST_RECOV;
               cnt_d   = CW'(RECOV_CYC - 1);
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_RECOV: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               q_exp_d = op_q;
               err_d   = err_q | (q_fb != op_q);
               ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE) || done_d;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         win_q   <= '0;
         op_q    <= 1'b0;
         s_q     <= 1'b0;
         r_q     <= 1'b0;
         gnt_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         q_exp_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         op_q    <= op_d;
         s_q     <= s_d;
         r_q     <= r_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         q_exp_q <= q_exp_d;
         err_q   <= err_d;
      end
   end

   assign s         = s_q;
   assign r         = r_q;
   assign bus.gnt   = gnt_q;
   assign bus.done  = done_q;
   assign bus.busy  = busy_q;
   assign bus.q_exp = q_exp_q;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Directed bench for sr_latch_ctrl (NREQ=4, PULSE_CYC=2, RECOV_CYC=1).
module tb_sr_latch_ctrl;

   logic clk;
   logic rst;
   logic s;
   logic r;
   logic q_fb;
   logic q_lat;
   logic fault_en;
   logic fault_val;
   int   n_chk;
   int   n_pass;

   sr_latch_ctrl_if #(.NREQ(4)) bus ();

   sr_latch_ctrl #(.NREQ(4), .PULSE_CYC(2), .RECOV_CYC(1)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .s    (s),
      .r    (r),
      .q_fb (q_fb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural cross-coupled NOR pair: set wins on s only, reset on r only, else hold.
   initial q_lat = 1'b0;
   always @(s or r) begin
      if (s && !r) q_lat = 1'b1;
      else if (r && !s) q_lat = 1'b0;
      else q_lat = q_lat;
   end
   assign q_fb = fault_en ? fault_val : q_lat;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (got === exp) begin
         n_pass = n_pass + 1;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Per-cycle invariants on every cycle, reset included.
   always @(negedge clk) begin
      check("s_r_exclusive", {31'd0, s & r}, 32'd0);
      check("gnt_onehot0", {31'd0, $onehot0(bus.gnt)}, 32'd1);
      check("done_implies_busy", {31'd0, bus.done & ~bus.busy}, 32'd0);
   end

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // One complete operation by a single requester with hand-computed timing.
   task automatic do_op(input int idx, input logic opv, input logic [3:0] exp_gnt, input logic exp_err);
      bus.req[idx] = 1'b1;
      bus.op[idx]  = opv;
      tick();
      check("op_gnt", {28'd0, bus.gnt}, {28'd0, exp_gnt});
      check("op_busy_t0", {31'd0, bus.busy}, 32'd1);
      check("op_s_t0", {31'd0, s}, 32'd0);
      bus.req[idx] = 1'b0;
      tick();
      check("op_s_t1", {31'd0, s}, {31'd0, opv});
      check("op_r_t1", {31'd0, r}, {31'd0, ~opv});
      check("op_gnt_t1", {28'd0, bus.gnt}, 32'd0);
      tick();
      check("op_s_t2", {31'd0, s}, {31'd0, opv});
      check("op_r_t2", {31'd0, r}, {31'd0, ~opv});
      tick();
      check("op_sr_t3", {30'd0, s, r}, 32'd0);
      check("op_done", {31'd0, bus.done}, 32'd1);
      check("op_busy_done", {31'd0, bus.busy}, 32'd1);
      check("op_q_exp", {31'd0, bus.q_exp}, {31'd0, opv});
      check("op_err", {31'd0, bus.err}, {31'd0, exp_err});
      tick();
      check("op_done_t4", {31'd0, bus.done}, 32'd0);
      check("op_busy_t4", {31'd0, bus.busy}, 32'd0);
   endtask

   initial begin
      logic [3:0] rr_exp [5];
      logic [3:0] g;
      int         k;
      rr_exp[0] = 4'b0001;
      rr_exp[1] = 4'b0010;
      rr_exp[2] = 4'b0100;
      rr_exp[3] = 4'b1000;
      rr_exp[4] = 4'b0001;
      n_chk     = 0;
      n_pass    = 0;
      fault_en  = 1'b0;
      fault_val = 1'b0;
      bus.req   = 4'b0000;
      bus.op    = 4'b0000;
      rst       = 1'b1;
      do_reset();

      check("rst_s", {31'd0, s}, 32'd0);
      check("rst_r", {31'd0, r}, 32'd0);
      check("rst_gnt", {28'd0, bus.gnt}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_q_exp", {31'd0, bus.q_exp}, 32'd0);
      check("rst_err", {31'd0, bus.err}, 32'd0);

      // Single set by requester 0.
      do_op(0, 1'b1, 4'b0001, 1'b0);
      check("set_q_fb", {31'd0, q_fb}, 32'd1);

      // Round-robin with all requesters held; each winner re-raises a cycle later.
      do_reset();
      bus.op  = 4'b1111;
      bus.req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         g = 4'b0000;
         k = 0;
         while (g == 4'b0000 && k < 10) begin
            tick();
            g = bus.gnt;
            k = k + 1;
         end
         check("rr_gnt", {28'd0, g}, {28'd0, rr_exp[n]});
         bus.req = bus.req & ~g;
         tick();
         bus.req = bus.req | g;
      end
      bus.req = 4'b0000;
      k = 0;
      while (bus.busy && k < 10) begin
         tick();
         k = k + 1;
      end
      check("rr_idle", {31'd0, bus.busy}, 32'd0);

      // Set by requester 0 then reset by requester 2.
      do_op(0, 1'b1, 4'b0001, 1'b0);
      check("sr_q_fb_set", {31'd0, q_fb}, 32'd1);
      do_op(2, 1'b0, 4'b0100, 1'b0);
      check("sr_q_fb_reset", {31'd0, q_fb}, 32'd0);

      // Stuck-low feedback during a set makes err sticky until reset.
      fault_en  = 1'b1;
      fault_val = 1'b0;
      do_op(1, 1'b1, 4'b0010, 1'b1);
      fault_en  = 1'b0;
      do_op(3, 1'b0, 4'b1000, 1'b1);
      do_op(0, 1'b1, 4'b0001, 1'b1);
      do_reset();
      check("fault_err_cleared", {31'd0, bus.err}, 32'd0);

      // Reset mid-pulse, with the pointer moved away from 0 beforehand.
      do_op(1, 1'b1, 4'b0010, 1'b0);
      bus.req[2] = 1'b1;
      bus.op[2]  = 1'b0;
      tick();
      check("mid_gnt", {28'd0, bus.gnt}, 32'd4);
      bus.req[2] = 1'b0;
      tick();
      check("mid_r_t1", {31'd0, r}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_sr_t2", {30'd0, s, r}, 32'd0);
      check("mid_gnt_t2", {28'd0, bus.gnt}, 32'd0);
      check("mid_busy_t2", {31'd0, bus.busy}, 32'd0);
      check("mid_q_exp_t2", {31'd0, bus.q_exp}, 32'd0);
      check("mid_err_t2", {31'd0, bus.err}, 32'd0);
      bus.op  = 4'b1111;
      bus.req = 4'b1111;
      tick();
      check("mid_next_gnt", {28'd0, bus.gnt}, 32'd1);
      bus.req = 4'b0000;
      k = 0;
      while (!bus.done && k < 10) begin
         tick();
         k = k + 1;
      end
      check("mid_next_done", {31'd0, bus.done}, 32'd1);
      check("mid_next_q_exp", {31'd0, bus.q_exp}, 32'd1);
      check("mid_next_err", {31'd0, bus.err}, 32'd0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
